bcd_subtractor_seq: RTL and testbench
=====================================

BCD_SUBTRACTOR_SEQ -- requirements
Module: bcd_subtractor_seq

Interface
REQ-001 Parameter NDIG, default 4: number of BCD digits per operand.
REQ-002 clk  input  1  rising-edge clock; one clock domain; reset is synchronous and active-high.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to begin a subtraction; accepted only while ready=1.
REQ-005 a  input  4*NDIG  minuend, packed BCD, digit 0 in bits [3:0].
REQ-006 b  input  4*NDIG  subtrahend, packed BCD, same packing as a.
REQ-007 ready  output  1  high in IDLE only.
REQ-008 done  output  1  one-cycle pulse when diff, neg and err are valid.
REQ-009 diff  output  4*NDIG  magnitude of a-b, packed BCD.
REQ-010 neg  output  1  high when a<b.
REQ-011 err  output  1  high when any nibble of the captured a or b exceeds 9.

Function
REQ-012 FSM states SHALL be IDLE, CHECK, SUB, FIX, DONE.
REQ-013 IDLE: ready=1; start=1 captures a and b into internal registers, clears the borrow and the digit index, and moves to CHECK.
REQ-014 CHECK, 1 cycle: any captured nibble >9 sets err=1 and moves to DONE; otherwise err=0 and the FSM moves to SUB.
REQ-015 SUB: processes one digit per cycle, LSD first, for NDIG cycles.
REQ-016 Digit rule: t = a_i - b_i - borrow_in. If t<0, the result digit is t+10 and borrow_out=1. Otherwise the result digit is t and borrow_out=0.
REQ-017 After the last SUB digit: final borrow=0 moves to DONE with neg=0; final borrow=1 moves to FIX with neg=1 and the borrow cleared.
REQ-018 FIX: for NDIG cycles, LSD first, applies the REQ-016 rule with minuend 0 and subtrahend = result digit i. This yields the ten's complement, i.e. the magnitude b-a.
REQ-019 DONE, 1 cycle: done=1, then the FSM returns to IDLE.
REQ-020 Latency, counted from the start-accepting edge to the cycle in which done is high:
- err case: 2 cycles.
- non-negative case: NDIG+2 cycles.
- negative case: 2*NDIG+2 cycles.
REQ-021 diff, neg and err SHALL hold their values from DONE until the next accepted start.
REQ-022 start while ready=0 SHALL be ignored; inputs a and b SHALL be sampled only at acceptance.
REQ-023 On err=1, diff SHALL be 0 and neg SHALL be 0.
REQ-024 Equal operands SHALL give diff=0 and neg=0; negative zero SHALL never be produced.

Reset
REQ-025 rst=1 at any clock edge forces IDLE and sets ready=1, done=0, diff=0, neg=0, err=0; the borrow and digit index are cleared.
REQ-026 Reset during CHECK, SUB or FIX SHALL abort the operation with no done pulse.
REQ-027 start asserted together with rst SHALL be ignored.

Structure
REQ-028 Shared package bcd_pkg holds the state enumeration, the BCD_MAX=9 and BCD_BASE=10 constants, and the default NDIG.
REQ-029 Sub-module bcd_digit_sub is combinational: inputs 4-bit x, 4-bit y, borrow-in; outputs 4-bit d, borrow-out. It is shared by the SUB and FIX phases, one instance.
REQ-030 The digit index SHALL be a counter of width clog2(NDIG)+1; no arithmetic wider than 5 bits per digit.

Verification (NDIG=4)
REQ-031 a=0042, b=0017, start -> done at start+6 with diff=0025, neg=0, err=0.
REQ-032 a=0017, b=0042 -> done at start+10 with diff=0025, neg=1.
REQ-033 a=1000, b=0001 -> diff=0999, neg=0 (full borrow chain). a=0000, b=9999 -> diff=9999, neg=1.
REQ-034 a=00A0, b=0001 -> done at start+2 with err=1, diff=0000, neg=0.
REQ-035 a=5555, b=5555 -> diff=0000, neg=0. A second start pulsed mid-operation is ignored and ready stays 0 until after DONE.
REQ-036 rst asserted in the 3rd SUB cycle -> next cycle ready=1 and diff=0, with no done pulse; a subsequent 0009-0003 gives diff=0006.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential BCD subtractor: FSM states and BCD constants.
package bcd_pkg;
  localparam int NDIG_DEFAULT = 4;
  localparam int BCD_MAX      = 9;
  localparam int BCD_BASE     = 10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_SUB,
    S_FIX,
    S_DONE
  } state_t;
endpackage

// File: rtl/bcd_digit_sub.sv
// One BCD digit of subtraction with borrow; shared by the SUB and FIX phases.
module bcd_digit_sub
  import bcd_pkg::*;
(
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       bin,
  output logic [3:0] d,
  output logic       bout
);

  logic [4:0] t;

  // Operands are at most 9, so t lies in [-10, 9] and bit 4 is the sign.
  always_comb begin
    t    = {1'b0, x} - {1'b0, y} - {4'b0000, bin};
    bout = t[4];
    d    = t[4] ? (t[3:0] + 4'(BCD_BASE)) : t[3:0];
  end

endmodule

// File: rtl/bcd_subtractor_seq.sv
// Sequential packed-BCD subtractor: one digit per cycle, ten's-complement fix-up
// pass when the result is negative so diff always carries the magnitude.
//
// state   | meaning
// S_IDLE  | ready for start, operands captured on acceptance
// S_CHECK | reject operands holding a nibble above 9
// S_SUB   | a - b, one digit per cycle, LSD first
// S_FIX   | 0 - result, one digit per cycle, turns a negative result into |a-b|
// S_DONE  | one-cycle done pulse, results stable
module bcd_subtractor_seq
  import bcd_pkg::*;
#(
  parameter int NDIG = NDIG_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [4*NDIG-1:0] a,
  input  logic [4*NDIG-1:0] b,
  output logic              ready,
  output logic              done,
  output logic [4*NDIG-1:0] diff,
  output logic              neg,
  output logic              err
);

  localparam int IW = $clog2(NDIG) + 1;
  localparam logic [IW-1:0] LAST = IW'(NDIG - 1);

  state_t            state;
  logic [4*NDIG-1:0] a_r;
  logic [4*NDIG-1:0] b_r;
  logic [4*NDIG-1:0] res;
  logic [4*NDIG-1:0] res_next;
  logic              borrow;
  logic [IW-1:0]     idx;
  logic [3:0]        x;
  logic [3:0]        y;
  logic [3:0]        d;
  logic              bout;
  logic              bad;

  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (a_r[4*i +: 4] > 4'(BCD_MAX) || b_r[4*i +: 4] > 4'(BCD_MAX)) bad = 1'b1;
    end
  end

  // FIX reuses the same digit slice with a zero minuend and the partial result.
  always_comb begin
    x = (state == S_FIX) ? 4'd0 : a_r[{idx, 2'b00} +: 4];
    y = (state == S_FIX) ? res[{idx, 2'b00} +: 4] : b_r[{idx, 2'b00} +: 4];
    res_next = res;
    res_next[{idx, 2'b00} +: 4] = d;
  end

  bcd_digit_sub u_digit (
    .x    (x),
    .y    (y),
    .bin  (borrow),
    .d    (d),
    .bout (bout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      ready  <= 1'b1;
      done   <= 1'b0;
      diff   <= '0;
      neg    <= 1'b0;
      err    <= 1'b0;
      borrow <= 1'b0;
      idx    <= '0;
      a_r    <= '0;
      b_r    <= '0;
      res    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            a_r    <= a;
            b_r    <= b;
            res    <= '0;
            borrow <= 1'b0;
            idx    <= '0;
            ready  <= 1'b0;
            state  <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (bad) begin
            err   <= 1'b1;
            diff  <= '0;
            neg   <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            err   <= 1'b0;
            state <= S_SUB;
          end
        end
        S_SUB: begin
          res    <= res_next;
          borrow <= bout;
          if (idx == LAST) begin
            idx <= '0;
            if (bout) begin
              borrow <= 1'b0;
              neg    <= 1'b1;
              state  <= S_FIX;
            end else begin
              neg   <= 1'b0;
              diff  <= res_next;
              done  <= 1'b1;
              state <= S_DONE;
            end
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_FIX: begin
          res    <= res_next;
          borrow <= bout;
          if (idx == LAST) begin
            idx    <= '0;
            borrow <= 1'b0;
            diff   <= res_next;
            done   <= 1'b1;
            state  <= S_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_DONE: begin
          ready <= 1'b1;
          state <= S_IDLE;
        end
        default: begin
          ready <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_subtractor_seq.sv
// Scoreboard bench for bcd_subtractor_seq with directed, hand-computed vectors.
module tb_bcd_subtractor_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        ready;
  logic        done;
  logic [15:0] diff;
  logic        neg;
  logic        err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [15:0] diff;
    logic        neg;
    logic        err;
    int          start_cyc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  bcd_subtractor_seq #(.NDIG(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .ready (ready),
    .done  (done),
    .diff  (diff),
    .neg   (neg),
    .err   (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no pulse", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("diff", {16'h0, diff}, {16'h0, mon_e.diff});
        chk("neg", {31'h0, neg}, {31'h0, mon_e.neg});
        chk("err", {31'h0, err}, {31'h0, mon_e.err});
        chk("latency", cyc - mon_e.start_cyc, mon_e.lat);
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!ready) chk("ready_timeout", {31'h0, ready}, 32'h1);
  endtask

  task automatic issue(input logic [15:0] av, input logic [15:0] bv, input logic [15:0] ed,
                       input logic en, input logic ee, input int el);
    exp_t e;
    wait_ready();
    a = av;
    b = bv;
    start = 1'b1;
    e.diff = ed;
    e.neg = en;
    e.err = ee;
    e.start_cyc = cyc;
    e.lat = el;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    a = 16'hFFFF;
    b = 16'hFFFF;
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) chk("done_timeout", 32'h0, 32'h1);
    @(negedge clk);
  endtask

  task automatic run_op(input logic [15:0] av, input logic [15:0] bv, input logic [15:0] ed,
                        input logic en, input logic ee, input int el);
    issue(av, bv, ed, en, ee, el);
    wait_done();
  endtask

  initial begin
    int ndone;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", {31'h0, ready}, 32'h1);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_diff", {16'h0, diff}, 32'h0);
    chk("rst_neg_err", {30'h0, neg, err}, 32'h0);

    run_op(16'h0042, 16'h0017, 16'h0025, 1'b0, 1'b0, 6);
    run_op(16'h0017, 16'h0042, 16'h0025, 1'b1, 1'b0, 10);
    run_op(16'h1000, 16'h0001, 16'h0999, 1'b0, 1'b0, 6);
    run_op(16'h1234, 16'h5678, 16'h4444, 1'b1, 1'b0, 10);
    run_op(16'h00A0, 16'h0001, 16'h0000, 1'b0, 1'b1, 2);
    run_op(16'h0001, 16'hF000, 16'h0000, 1'b0, 1'b1, 2);

    // Equal operands with a stray start pulse while busy.
    issue(16'h5555, 16'h5555, 16'h0000, 1'b0, 1'b0, 6);
    for (int i = 0; i < 20 && !done; i++) begin
      chk("busy_ready_low", {31'h0, ready}, 32'h0);
      if (i == 2) begin
        a = 16'h1111;
        b = 16'h0000;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    wait_done();
    chk("after_done_ready", {31'h0, ready}, 32'h1);
    @(negedge clk);
    chk("no_extra_start", {31'h0, ready}, 32'h1);

    run_op(16'h0000, 16'h9999, 16'h9999, 1'b1, 1'b0, 10);
    chk("hold_diff", {16'h0, diff}, 32'h9999);
    chk("hold_neg", {31'h0, neg}, 32'h1);

    // Abort in the third SUB cycle; start alongside rst must be ignored.
    wait_ready();
    a = 16'h0042;
    b = 16'h0017;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    chk("abort_ready", {31'h0, ready}, 32'h1);
    chk("abort_diff", {16'h0, diff}, 32'h0);
    chk("abort_neg_err", {30'h0, neg, err}, 32'h0);
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("start_with_rst_ignored", {31'h0, ready}, 32'h1);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    chk("abort_no_done", ndone, 0);

    run_op(16'h0009, 16'h0003, 16'h0006, 1'b0, 1'b0, 6);
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion by %0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
